priority_dispatch_2d: RTL and testbench
=======================================

PRIORITY_DISPATCH_2D -- requirements
Module: priority_dispatch_2d

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width per channel.
REQ-002 The block SHALL have parameter CNT, default 5, giving the number of output channels; index 0 is highest priority.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port in_vld, input, 1 bit: input word valid.
REQ-006 The block SHALL have port in_rdy, output, 1 bit: input word accepted this cycle when in_vld is also high.
REQ-007 The block SHALL have port in_dat, input, WIDTH bits: input word.
REQ-008 The block SHALL have port en, input, CNT bits: per-channel dispatch enable.
REQ-009 The block SHALL have port out_vld, output, CNT bits: per-channel output valid.
REQ-010 The block SHALL have port out_rdy, input, CNT bits: per-channel sink ready.
REQ-011 The block SHALL have port out_dat, output, [CNT-1:0][WIDTH-1:0]: per-channel output word.
REQ-012 The block SHALL have port last_sel, output, CNT bits: one-hot channel that took the most recent accepted word.
REQ-013 The block SHALL have port acc_cnt, output, 16 bits: count of accepted input words.

Function
REQ-014 Each channel SHALL hold exactly one registered slot made of out_vld[i] and out_dat[i].
REQ-015 The block SHALL define free[i] = !out_vld[i] | out_rdy[i], so a slot draining this cycle counts as free.
REQ-016 The block SHALL define elig[i] = en[i] & free[i].
REQ-017 in_rdy SHALL equal |elig, combinational from en, out_vld and out_rdy; in_rdy SHALL NOT depend on in_vld.
REQ-018 On a cycle with in_vld & in_rdy, the target channel t SHALL be the lowest index i with elig[i]=1.
REQ-019 On that cycle, at the next edge, out_dat[t] SHALL load in_dat, out_vld[t] SHALL be set to 1, and last_sel SHALL be set to one-hot t. Latency is one cycle.
REQ-020 For every channel i not loaded in a cycle with out_vld[i] & out_rdy[i], out_vld[i] SHALL clear at the next edge. out_dat[i] SHALL hold its value.
REQ-021 When the target channel is also draining in the same cycle, the load SHALL win: out_vld[t] stays 1 and the new word replaces the old one with no bubble.
REQ-022 At most one channel SHALL be loaded per cycle.
REQ-023 While out_vld[i]=1 and out_rdy[i]=0, out_dat[i] SHALL remain stable.
REQ-024 Deasserting en[i] SHALL only block new loads into channel i; a word already held in channel i SHALL remain valid until drained.
REQ-025 acc_cnt SHALL increment by 1 on each accepted word and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 When no word is accepted, last_sel and acc_cnt SHALL hold their values.
REQ-027 If en is all zeros, in_rdy SHALL be 0 and all slots SHALL continue to drain normally.

Reset
REQ-028 When rst_n is low, out_vld, last_sel and acc_cnt SHALL clear to 0 asynchronously.
REQ-029 out_dat SHALL reset to 0.
REQ-030 While rst_n is low, in_rdy SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL discard all held words. No output valid SHALL appear until a new word is accepted after reset is released.

Verification (CNT=5, WIDTH=32)
REQ-032 Priority: en=5'b11111, all out_rdy=0, slots empty, three in_vld cycles with words A, B, C -> A goes to ch0, B to ch1, C to ch2; last_sel=00100; acc_cnt=3.
REQ-033 Fill and back-pressure: all slots full, out_rdy=0 -> in_rdy=0 and acc_cnt unchanged. Then raise out_rdy[3] only -> the next word loads ch3 the same cycle with out_vld[3] staying 1.
REQ-034 Enable mask: en=5'b10100, slots empty, words D then E -> D goes to ch2, E goes to ch4. Then clear en[2] while ch2 is held -> ch2 keeps D until out_rdy[2]=1.
REQ-035 Counter wrap: preload 0xFFFF accepted words (or force the count), then accept one more -> acc_cnt=0x0000.
REQ-036 Async reset: three slots valid, pull rst_n low between clock edges -> out_vld=0 and acc_cnt=0 immediately. After release, in_rdy=1 with en nonzero.
REQ-037 Random stress: random in_vld, out_rdy and en over 10k cycles -> the scoreboard confirms every accepted word appears exactly once on the correct lowest-eligible channel, and that data stays stable under stall.

Source files
------------

// File: rtl/priority_dispatch_2d.sv
// Priority dispatcher: each accepted input word goes to the lowest-index enabled
// channel whose single-entry slot is free or draining this cycle.

module pd_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // A load in the same cycle as a drain wins, so the slot refills without a bubble.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;
endmodule

module priority_dispatch_2d #(
    parameter int WIDTH = 32,
    parameter int CNT   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [WIDTH-1:0]          in_dat,
    input  logic [CNT-1:0]            en,
    output logic [CNT-1:0]            out_vld,
    input  logic [CNT-1:0]            out_rdy,
    output logic [CNT-1:0][WIDTH-1:0] out_dat,
    output logic [CNT-1:0]            last_sel,
    output logic [15:0]               acc_cnt
);
    logic [CNT-1:0] free, elig, tgt, load;
    logic           accept;
    logic [CNT-1:0] last_sel_q, last_sel_d;
    logic [15:0]    acc_cnt_q, acc_cnt_d;

    assign free   = ~out_vld | out_rdy;
    assign elig   = en & free;
    // Isolate the lowest set bit: that is the highest-priority eligible channel.
    assign tgt    = elig & (~elig + CNT'(1));
    assign in_rdy = rst_n & (|elig);
    assign accept = in_vld & in_rdy;
    assign load   = tgt & {CNT{accept}};

    for (genvar i = 0; i < CNT; i++) begin : g_ch
        pd_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[i]),
            .drain_i (out_rdy[i]),
            .dat_i   (in_dat),
            .vld_o   (out_vld[i]),
            .dat_o   (out_dat[i])
        );
    end

    always_comb begin
        last_sel_d = last_sel_q;
        acc_cnt_d  = acc_cnt_q;
        if (accept) begin
            last_sel_d = tgt;
            acc_cnt_d  = acc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sel_q <= '0;
            acc_cnt_q  <= '0;
        end else begin
            last_sel_q <= last_sel_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    assign last_sel = last_sel_q;
    assign acc_cnt  = acc_cnt_q;
endmodule

// File: tb/tb_priority_dispatch_2d.sv
// Directed checks plus a cycle-accurate reference model driven by random traffic.

module tb_priority_dispatch_2d;
    localparam int W = 32;
    localparam int C = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_vld;
    logic              in_rdy;
    logic [W-1:0]      in_dat;
    logic [C-1:0]      en;
    logic [C-1:0]      out_vld;
    logic [C-1:0]      out_rdy;
    logic [C-1:0][W-1:0] out_dat;
    logic [C-1:0]      last_sel;
    logic [15:0]       acc_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    priority_dispatch_2d #(.WIDTH(W), .CNT(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_dat   (in_dat),
        .en       (en),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_dat  (out_dat),
        .last_sel (last_sel),
        .acc_cnt  (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h want %h", tag, act, exp);
        else n_pass++;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, CC = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004, E = 32'hEEEE_0005;

    logic [C-1:0]        m_vld, m_last, m_elig;
    logic [C-1:0][W-1:0] m_dat;
    logic [15:0]         m_acc;
    int                  t;

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; en = 5'b11111; out_rdy = '0;
        #12;
        chk("rst_vld",  out_vld, 0);
        chk("rst_acc",  acc_cnt, 0);
        chk("rst_last", last_sel, 0);
        chk("rst_rdy",  in_rdy, 0);
        chk("rst_dat0", out_dat[0], 0);
        rst_n = 1'b1;
        step();

        // Priority fill A,B,C into ch0..ch2
        in_vld = 1'b1; in_dat = A;  step();
        in_dat = B;  step();
        in_dat = CC; step();
        chk("pri_vld", out_vld, 5'b00111);
        chk("pri_d0", out_dat[0], A);
        chk("pri_d1", out_dat[1], B);
        chk("pri_d2", out_dat[2], CC);
        chk("pri_last", last_sel, 5'b00100);
        chk("pri_acc", acc_cnt, 3);

        // Fill remaining, then back-pressure
        in_dat = 32'h1111_0003; step();
        in_dat = 32'h1111_0004; step();
        chk("full_vld", out_vld, 5'b11111);
        #1 chk("full_rdy", in_rdy, 0);
        in_dat = 32'h1111_0009; step();
        chk("full_acc", acc_cnt, 5);
        out_rdy = 5'b01000; in_dat = 32'h3333_0003;
        #1 chk("bp_rdy", in_rdy, 1);
        step();
        chk("bp_vld", out_vld, 5'b11111);
        chk("bp_d3", out_dat[3], 32'h3333_0003);
        chk("bp_last", last_sel, 5'b01000);
        chk("bp_acc", acc_cnt, 6);

        // Drain all, then enable mask
        in_vld = 1'b0; out_rdy = 5'b11111; step();
        chk("drain_vld", out_vld, 0);
        out_rdy = '0; en = 5'b10100; in_vld = 1'b1; in_dat = D; step();
        in_dat = E; step();
        chk("mask_vld", out_vld, 5'b10100);
        chk("mask_d2", out_dat[2], D);
        chk("mask_d4", out_dat[4], E);
        in_vld = 1'b0; en = 5'b10000;
        #1 chk("mask_rdy", in_rdy, 0);
        step(); step();
        chk("hold_vld", out_vld, 5'b10100);
        chk("hold_d2", out_dat[2], D);
        out_rdy = 5'b00100; step();
        chk("hold_drain", out_vld, 5'b10000);

        // en all zero still drains
        en = '0; out_rdy = 5'b11111;
        #1 chk("en0_rdy", in_rdy, 0);
        step();
        chk("en0_vld", out_vld, 0);

        // Async reset mid-operation
        en = 5'b11111; out_rdy = '0; in_vld = 1'b1;
        in_dat = A; step(); in_dat = B; step(); in_dat = CC; step();
        chk("ar_pre", out_vld, 5'b00111);
        in_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", out_vld, 0);
        chk("ar_acc", acc_cnt, 0);
        chk("ar_rdy", in_rdy, 0);
        step();
        rst_n = 1'b1;
        #1 chk("ar_rel_rdy", in_rdy, 1);
        step();
        chk("ar_rel_vld", out_vld, 0);

        // Counter wrap: ch0 refills every cycle while draining
        en = 5'b00001; out_rdy = 5'b11111; in_vld = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_dat = i;
            step();
        end
        chk("wrap_ffff", acc_cnt, 16'hFFFF);
        chk("wrap_v0", out_vld, 5'b00001);
        in_dat = 32'hFEED_F00D; step();
        chk("wrap_zero", acc_cnt, 0);
        chk("wrap_d0", out_dat[0], 32'hFEED_F00D);

        // Random stress against reference model, starting from reset
        in_vld = 1'b0;
        rst_n = 1'b0; #3 rst_n = 1'b1;
        step();
        m_vld = '0; m_dat = '0; m_last = '0; m_acc = '0;
        for (int n = 0; n < 10000; n++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            en      = C'($urandom);
            out_rdy = C'($urandom) & C'($urandom);
            in_dat  = $urandom;
            #1;
            m_elig = en & (~m_vld | out_rdy);
            chk("st_rdy", in_rdy, |m_elig);
            t = -1;
            for (int i = C - 1; i >= 0; i--) if (m_elig[i]) t = i;
            for (int i = 0; i < C; i++) if (out_rdy[i]) m_vld[i] = 1'b0;
            if (in_vld && t >= 0) begin
                m_vld[t]  = 1'b1;
                m_dat[t]  = in_dat;
                m_last    = C'(1) << t;
                m_acc     = m_acc + 16'd1;
            end
            step();
            chk("st_vld", out_vld, m_vld);
            chk("st_last", last_sel, m_last);
            chk("st_acc", acc_cnt, m_acc);
            for (int i = 0; i < C; i++)
                if (m_vld[i]) chk("st_dat", out_dat[i], m_dat[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
